pipelined_addsub: RTL and testbench
===================================

// Module: pipelined_addsub
// PURPOSE
//  Parametrised successor to the fixed 4-stage CLA adder: W-bit add/subtract split into S carry-chained
//  segments, one segment resolved per stage, carry registered between stages. Adds valid/ready
//  back-pressure, subtract mode, carry/borrow out, signed overflow and a sideband tag. Sits between an
//  operand-issue unit and a result consumer that may stall.
// PARAMETERS
//  W    128  operand/result width (>= S)
//  S    4    pipeline stages = segment count; SEG = ceil(W/S), last segment = W-(S-1)*SEG bits (>=1)
//  TW   4    tag width passed through unchanged
// PORTS
//  clk        in   1   clock, all state on posedge
//  rstn       in   1   synchronous reset, active low
//  in_valid   in   1   operand beat valid
//  in_ready   out  1   block accepts beat this cycle
//  op1        in   W   operand A
//  op2        in   W   operand B
//  cin        in   1   carry-in (add) / borrow-in (sub)
//  sub        in   1   0: A+B+cin ; 1: A-B-cin
//  tag        in   TW  sideband id
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer accepts result
//  res        out  W   result mod 2^W
//  cout       out  1   add: carry out; sub: borrow out (1 when A < B+cin unsigned)
//  ovf        out  1   signed two's-complement overflow
//  out_tag    out  TW  tag of the beat on res
// BEHAVIOUR
//  - Reset (rstn=0 at posedge): all stage valids, out_valid, res, cout, ovf, out_tag cleared to 0;
//    in-flight beats discarded, no partial result ever emitted. in_ready=1 in the cycle after reset.
//  - Global enable en = ~out_valid | out_ready; in_ready = en (combinational, no dependence on in_valid).
//  - Accept when in_valid & in_ready. Stage 0 captures B' = sub ? ~op2 : op2, ci = sub ? ~cin : cin,
//    computes segment 0 of A+B'+ci; upper segments of A/B' and tag shift alongside.
//  - Stage k (1..S-1), on en: adds segment k using the carry registered by stage k-1; lower result
//    segments move forward unchanged. Stage 0 captures even when in_valid=0 (valid bit = 0: bubble).
//  - When en=0 every stage register, including valid bits, holds; no beat is lost or duplicated.
//  - Latency: accepted at edge t with no stall -> out_valid=1 after edge t+S-1 (S stages incl. output).
//    Throughput one beat/cycle when out_ready held high.
//  - cout = final carry ^ sub. ovf = (A[W-1]==B'[W-1]) & (res[W-1]!=A[W-1]).
//  - Outputs res/cout/ovf/out_tag are registered, stable while out_valid & ~out_ready.
//  - Result bits of invalid beats are don't-care internally; output regs update only on valid beats.
//  - S=1 legal: single-cycle registered adder, same handshake. W not multiple of S: last segment short.
// STRUCTURE
//  - Package addsub_pkg: localparam function seg_lo(k)/seg_w(k) computing segment base and width from
//    W,S (replaces hard-coded width tables); struct type for stage payload {valid, a, b, r, c, sub, tag}.
//  - One sub-module addsub_seg_stage: one stage register of the payload plus the segment adder for its
//    slice, instantiated S times in a generate loop; top holds handshake and output register.
// TESTING  (W=128, S=4, TW=4 unless noted)
//  1 add: A=2^128-1, B=1, cin=0, tag=3 -> res=0, cout=1, ovf=0, out_tag=3, out_valid 4 cycles after accept.
//  2 sub: A=5, B=7, cin=0 -> res=2^128-2, cout=1 (borrow), ovf=0; A=2^127, B=1 -> res=2^127-1, ovf=1.
//  3 stream 16 back-to-back random beats, out_ready=1 -> 16 results in order, one per cycle, match model.
//  4 back-pressure: out_ready=0 for 10 cycles mid-stream -> in_ready=0 while out_valid held, res stable,
//    no loss/dup; resume -> order preserved.
//  5 rstn=0 for one cycle with 3 beats in flight -> next cycle out_valid=0, res=0; no stale result later.
//  6 W=10, S=3 (segments 4,4,2): A=1023, B=1, cin=1 -> res=1, cout=1; carry ripples across all segments.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared helpers for the segmented add/sub pipeline.
// Segment geometry derived from width and stage count.
package addsub_pkg;

    function automatic int seg_size(input int w, input int s);
        return (w + s - 1) / s;
    endfunction

    function automatic int seg_lo(input int k, input int w, input int s);
        return k * seg_size(w, s);
    endfunction

    // The top segment takes whatever bits remain, so it may be short.
    function automatic int seg_w(input int k, input int w, input int s);
        if (k == s - 1)
            return w - (s - 1) * seg_size(w, s);
        return seg_size(w, s);
    endfunction

endpackage

// File: rtl/addsub_seg_stage.sv
// One pipeline stage: payload register plus the adder for its slice.
// The last stage doubles as the output register and ignores bubbles.
module addsub_seg_stage
    import addsub_pkg::*;
#(
    parameter int  LO    = 0,
    parameter int  SW    = 32,
    parameter bit  LAST  = 1'b0,
    parameter type pay_t = logic
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  pay_t d,
    output pay_t q
);

    pay_t        nxt;
    logic [SW:0] sum;

    always_comb begin
        sum = {1'b0, d.a[LO +: SW]}
            + {1'b0, d.b[LO +: SW]}
            + {{SW{1'b0}}, d.c};
        nxt = d;
        nxt.r[LO +: SW] = sum[SW-1:0];
        nxt.c = sum[SW];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q <= '0;
        end else if (en) begin
            if (!LAST || d.valid)
                q <= nxt;
            else
                q.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipelined_addsub.sv
// W-bit add/subtract resolved one carry-chained segment per stage,
// with a single global enable giving valid/ready back-pressure.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int W  = 128,
    parameter int S  = 4,
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  op1,
    input  logic [W-1:0]  op2,
    input  logic          cin,
    input  logic          sub,
    input  logic [TW-1:0] tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  res,
    output logic          cout,
    output logic          ovf,
    output logic [TW-1:0] out_tag
);

    typedef struct packed {
        logic          valid;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [W-1:0]  r;
        logic          c;
        logic          sub;
        logic [TW-1:0] tag;
    } pay_t;

    pay_t       s_in;
    pay_t [S:0] stg;
    pay_t       fin;
    logic       en;
    logic       unused_bits;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // Subtract as A + ~B + ~borrow; the borrow sense is restored at cout.
    always_comb begin
        s_in       = '0;
        s_in.valid = in_valid;
        s_in.a     = op1;
        s_in.b     = sub ? ~op2 : op2;
        s_in.c     = cin ^ sub;
        s_in.sub   = sub;
        s_in.tag   = tag;
    end

    assign stg[0] = s_in;

    for (genvar k = 0; k < S; k++) begin : g_stage
        addsub_seg_stage #(
            .LO   (seg_lo(k, W, S)),
            .SW   (seg_w(k, W, S)),
            .LAST (k == S - 1),
            .pay_t(pay_t)
        ) u_stage (
            .clk (clk),
            .rstn(rstn),
            .en  (en),
            .d   (stg[k]),
            .q   (stg[k+1])
        );
    end

    assign fin       = stg[S];
    assign out_valid = fin.valid;
    assign res       = fin.r;
    assign cout      = fin.c ^ fin.sub;
    assign ovf       = (fin.a[W-1] == fin.b[W-1])
                     & (fin.r[W-1] != fin.a[W-1]);
    assign out_tag   = fin.tag;

    assign unused_bits = ^{fin.a, fin.b};

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: 128/4 main instance
// plus a 10-bit, 3-stage instance with a short top segment.
module tb_pipelined_addsub;

    localparam int W  = 128;
    localparam int TW = 4;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          cin;
        logic          sub;
        logic [TW-1:0] tag;
        logic [W-1:0]  res;
        logic          cout;
        logic          ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0]  res;
        logic          cout;
        logic          ovf;
        logic [TW-1:0] tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          in_valid, in_ready;
    logic [W-1:0]  op1, op2;
    logic          cin, sub;
    logic [TW-1:0] tag;
    logic          out_valid, out_ready;
    logic [W-1:0]  res;
    logic          cout, ovf;
    logic [TW-1:0] out_tag;

    logic          in_valid2, in_ready2;
    logic [9:0]    op1_2, op2_2;
    logic          cin2, sub2;
    logic [1:0]    tag2;
    logic          out_valid2, out_ready2;
    logic [9:0]    res2;
    logic          cout2, ovf2;
    logic [1:0]    out_tag2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipelined_addsub #(.W(W), .S(4), .TW(TW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op1      (op1),
        .op2      (op2),
        .cin      (cin),
        .sub      (sub),
        .tag      (tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .res      (res),
        .cout     (cout),
        .ovf      (ovf),
        .out_tag  (out_tag)
    );

    pipelined_addsub #(.W(10), .S(3), .TW(2)) dut2 (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid2),
        .in_ready (in_ready2),
        .op1      (op1_2),
        .op2      (op2_2),
        .cin      (cin2),
        .sub      (sub2),
        .tag      (tag2),
        .out_valid(out_valid2),
        .out_ready(out_ready2),
        .res      (res2),
        .cout     (cout2),
        .ovf      (ovf2),
        .out_tag  (out_tag2)
    );

    task automatic chk(input string nm,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic c, input logic s,
                                   input logic [TW-1:0] t);
        logic [W:0] f;
        exp_t e;
        if (!s) begin
            f = {1'b0, a} + {1'b0, b} + (W+1)'(c);
            e.cout = f[W];
            e.ovf = (a[W-1] == b[W-1]) && (f[W-1] != a[W-1]);
        end else begin
            f = {1'b0, a} - {1'b0, b} - (W+1)'(c);
            e.cout = ({1'b0, a} < ({1'b0, b} + (W+1)'(c)));
            e.ovf = (a[W-1] != b[W-1]) && (f[W-1] != a[W-1]);
        end
        e.res = f[W-1:0];
        e.tag = t;
        return e;
    endfunction

    task automatic apply_vec(input vec_t v, input string nm);
        int cyc;
        @(negedge clk);
        op1 = v.a; op2 = v.b; cin = v.cin;
        sub = v.sub; tag = v.tag; in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({nm, " in_ready"}, W'(in_ready), W'(1));
        cyc = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            cyc++;
        end while (!out_valid && cyc < 20);
        chk({nm, " latency"}, W'(cyc), W'(4));
        chk({nm, " res"}, res, v.res);
        chk({nm, " cout"}, W'(cout), W'(v.cout));
        chk({nm, " ovf"}, W'(ovf), W'(v.ovf));
        chk({nm, " tag"}, W'(out_tag), W'(v.tag));
    endtask

    task automatic run_stream(input int n, input int st_at,
                              input int st_len, input string nm);
        exp_t q[$];
        exp_t e;
        int sent = 0, got = 0, cyc = 0;
        int first = -1, last = -1;
        logic pend = 1'b0;
        logic held_v = 1'b0;
        logic [W-1:0] held_r = '0;
        logic [TW-1:0] held_t = '0;
        while (got < n && cyc < 300) begin
            @(negedge clk);
            cyc++;
            out_ready = !(cyc >= st_at && cyc < st_at + st_len);
            #1;
            if (held_v) begin
                chk({nm, " hold valid"}, W'(out_valid), W'(1));
                chk({nm, " hold res"}, res, held_r);
                chk({nm, " hold tag"}, W'(out_tag), W'(held_t));
            end
            if (out_valid && !out_ready)
                chk({nm, " in_ready stall"}, W'(in_ready), W'(0));
            if (out_valid && out_ready) begin
                chk({nm, " no dup"}, W'(q.size() > 0), W'(1));
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk({nm, " res"}, res, e.res);
                    chk({nm, " cout"}, W'(cout), W'(e.cout));
                    chk({nm, " ovf"}, W'(ovf), W'(e.ovf));
                    chk({nm, " tag"}, W'(out_tag), W'(e.tag));
                end
                got++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            held_v = out_valid && !out_ready;
            held_r = res;
            held_t = out_tag;
            if (sent < n) begin
                if (!pend) begin
                    op1 = {$urandom, $urandom, $urandom, $urandom};
                    op2 = {$urandom, $urandom, $urandom, $urandom};
                    cin = 1'($urandom);
                    sub = 1'($urandom);
                    tag = TW'(sent);
                    pend = 1'b1;
                end
                in_valid = 1'b1;
                if (in_ready) begin
                    q.push_back(model(op1, op2, cin, sub, tag));
                    sent++;
                    pend = 1'b0;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk({nm, " count"}, W'(got), W'(n));
        chk({nm, " leftover"}, W'(q.size()), W'(0));
        if (st_len == 0)
            chk({nm, " back-to-back"}, W'(last - first), W'(n - 1));
        repeat (6) begin
            @(negedge clk);
            chk({nm, " drained"}, W'(out_valid), W'(0));
        end
    endtask

    task automatic apply2(input logic [9:0] a, input logic [9:0] b,
                          input logic c, input logic s,
                          input logic [9:0] er, input logic ec,
                          input logic eo, input string nm);
        int cyc;
        @(negedge clk);
        op1_2 = a; op2_2 = b; cin2 = c; sub2 = s;
        tag2 = 2'd2; in_valid2 = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            in_valid2 = 1'b0;
            cyc++;
        end while (!out_valid2 && cyc < 20);
        chk({nm, " latency"}, W'(cyc), W'(3));
        chk({nm, " res"}, W'(res2), W'(er));
        chk({nm, " cout"}, W'(cout2), W'(ec));
        chk({nm, " ovf"}, W'(ovf2), W'(eo));
        chk({nm, " tag"}, W'(out_tag2), W'(2));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] msb;
        vec_t vt[10];

        ones = '1;
        msb  = W'(1) << (W - 1);
        rstn = 1'b0;
        in_valid = 1'b0; op1 = '0; op2 = '0;
        cin = 1'b0; sub = 1'b0; tag = '0;
        out_ready = 1'b1;
        in_valid2 = 1'b0; op1_2 = '0; op2_2 = '0;
        cin2 = 1'b0; sub2 = 1'b0; tag2 = '0;
        out_ready2 = 1'b1;

        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("reset out_valid", W'(out_valid), W'(0));
        chk("reset res", res, '0);
        chk("reset cout", W'(cout), W'(0));
        chk("reset ovf", W'(ovf), W'(0));
        chk("reset tag", W'(out_tag), W'(0));
        chk("reset in_ready", W'(in_ready), W'(1));

        vt[0] = '{ones, W'(1), 1'b0, 1'b0, 4'd3,
                  W'(0), 1'b1, 1'b0};
        vt[1] = '{W'(5), W'(7), 1'b0, 1'b1, 4'd1,
                  ones - W'(1), 1'b1, 1'b0};
        vt[2] = '{msb, W'(1), 1'b0, 1'b1, 4'd2,
                  msb - W'(1), 1'b0, 1'b1};
        vt[3] = '{msb - W'(1), W'(1), 1'b0, 1'b0, 4'd4,
                  msb, 1'b0, 1'b1};
        vt[4] = '{W'(64'hFFFF_FFFF_FFFF_FFFF), W'(0), 1'b1,
                  1'b0, 4'd5, W'(1) << 64, 1'b0, 1'b0};
        vt[5] = '{W'(10), W'(3), 1'b1, 1'b1, 4'd6,
                  W'(6), 1'b0, 1'b0};
        vt[6] = '{W'(0), W'(0), 1'b1, 1'b1, 4'd7,
                  ones, 1'b1, 1'b0};
        vt[7] = '{msb, msb, 1'b0, 1'b0, 4'd8,
                  W'(0), 1'b1, 1'b1};
        vt[8] = '{W'(32'hFFFF_FFFF), W'(1), 1'b0, 1'b0, 4'd9,
                  W'(1) << 32, 1'b0, 1'b0};
        vt[9] = '{W'(123), W'(123), 1'b0, 1'b1, 4'd15,
                  W'(0), 1'b0, 1'b0};

        for (int i = 0; i < 10; i++)
            apply_vec(vt[i], $sformatf("vec%0d", i));

        run_stream(16, 0, 0, "stream");
        run_stream(16, 5, 10, "bp");

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            op1 = ones; op2 = ones; cin = 1'b1;
            sub = 1'b0; tag = TW'(i + 9); in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        chk("rst mid out_valid", W'(out_valid), W'(0));
        chk("rst mid res", res, '0);
        chk("rst mid cout", W'(cout), W'(0));
        chk("rst mid tag", W'(out_tag), W'(0));
        rstn = 1'b1;
        #1;
        chk("rst mid in_ready", W'(in_ready), W'(1));
        repeat (8) begin
            @(negedge clk);
            chk("rst no stale", W'(out_valid), W'(0));
        end

        apply2(10'd1023, 10'd1, 1'b1, 1'b0, 10'd1, 1'b1, 1'b0, "w10 ripple");
        apply2(10'd0, 10'd1, 1'b0, 1'b1, 10'd1023, 1'b1, 1'b0, "w10 borrow");
        apply2(10'd511, 10'd1, 1'b0, 1'b0, 10'd512, 1'b0, 1'b1, "w10 ovf");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
